// File: rtl/ripple_add_sequencer.sv
// ============================================================================
// Module   : ripple_add_sequencer
// Brief    : Multi-cycle adder using one 4-bit ripple-carry slice per nibble.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_done_valid,
  input  logic             i_done_ready,
  output logic             o_busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDXW-1:0]  r_idx;

  logic             w_accept;
  logic             w_last;
  logic             w_start_ready;
  logic             w_busy;
  logic             w_done_valid;
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [3:0]       w_slice_sum;
  logic [4:0]       w_c;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_last = (r_idx == C_LAST_IDX);

  always_comb begin
    w_state_nxt   = r_state;
    w_start_ready = 1'b0;
    w_busy        = 1'b0;
    w_done_valid  = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start_ready = 1'b1;
        if (i_start_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done_valid = 1'b1;
        if (i_done_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared 4-bit ripple-carry slice, fed from the captured operands only
  // ---------------------------------------------------------------------------
  assign w_nib_a = r_a[{r_idx, 2'b00} +: 4];
  assign w_nib_b = r_b[{r_idx, 2'b00} +: 4];
  assign w_c[0]  = r_carry;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign w_slice_sum[g] = w_nib_a[g] ^ w_nib_b[g] ^ w_c[g];
    assign w_c[g+1]       = (w_nib_a[g] & w_nib_b[g]) |
                            (w_c[g] & (w_nib_a[g] ^ w_nib_b[g]));
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= i_cin;
      r_sum   <= '0;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
      r_carry                    <= w_c[4];
      if (w_last) begin
        r_cout <= w_c[4];
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign o_start_ready = w_start_ready;
  assign o_busy        = w_busy;
  assign o_done_valid  = w_done_valid;
  assign o_sum         = r_sum;
  assign o_cout        = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_ripple_add_sequencer.sv
// ============================================================================
// Module   : tb_ripple_add_sequencer
// Brief    : Directed-vector and sequence bench for ripple_add_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ripple_add_sequencer;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] tb_a;
  logic [15:0] tb_b;
  logic        tb_cin;
  logic [15:0] sum;
  logic        cout;
  logic        done_valid;
  logic        done_ready;
  logic        busy;

  logic        w4_start_valid;
  logic        w4_start_ready;
  logic [3:0]  w4_a;
  logic [3:0]  w4_b;
  logic        w4_cin;
  logic [3:0]  w4_sum;
  logic        w4_cout;
  logic        w4_done_valid;
  logic        w4_done_ready;
  logic        w4_busy;

  int n_checks = 0;
  int n_err    = 0;

  ripple_add_sequencer #(.WIDTH(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_start_valid(start_valid),
    .o_start_ready(start_ready),
    .i_a          (tb_a),
    .i_b          (tb_b),
    .i_cin        (tb_cin),
    .o_sum        (sum),
    .o_cout       (cout),
    .o_done_valid (done_valid),
    .i_done_ready (done_ready),
    .o_busy       (busy)
  );

  ripple_add_sequencer #(.WIDTH(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .i_start_valid(w4_start_valid),
    .o_start_ready(w4_start_ready),
    .i_a          (w4_a),
    .i_b          (w4_b),
    .i_cin        (w4_cin),
    .o_sum        (w4_sum),
    .o_cout       (w4_cout),
    .o_done_valid (w4_done_valid),
    .i_done_ready (w4_done_ready),
    .o_busy       (w4_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 16-bit instance with optional idle/response gaps
  task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] exp_s, input logic exp_co,
                       input int pre, input int resp);
    int n;
    repeat (pre) tick();
    n = 0;
    while (!start_ready && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_ready"}, 32'(start_ready), 32'd1);
    tb_a = a; tb_b = b; tb_cin = c; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tb_a = 16'($urandom); tb_b = 16'($urandom); tb_cin = 1'($urandom);
    n = 0;
    while (!done_valid && n < 16) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd4);
    chk({nm, "_sum"}, 32'(sum), 32'(exp_s));
    chk({nm, "_cout"}, 32'(cout), 32'(exp_co));
    repeat (resp) tick();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk({nm, "_release"}, {29'd0, start_ready, done_valid, busy}, 32'b100);
  endtask

  task automatic do_op4(input string nm, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [3:0] exp_s, input logic exp_co);
    int n;
    w4_a = a; w4_b = b; w4_cin = c; w4_start_valid = 1'b1;
    tick();
    w4_start_valid = 1'b0;
    w4_a = ~a; w4_b = ~b; w4_cin = ~c;
    n = 0;
    while (!w4_done_valid && n < 8) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd1);
    chk({nm, "_result"}, {27'd0, w4_cout, w4_sum}, {27'd0, exp_co, exp_s});
    w4_done_ready = 1'b1;
    tick();
    w4_done_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] fill[4];
    logic [16:0] ref_v;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    int          n;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vecs[8] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    vecs[9] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    fill[0] = 16'h0006; fill[1] = 16'h0056; fill[2] = 16'h0556; fill[3] = 16'h5556;

    rst = 1'b1;
    start_valid = 1'b0; done_ready = 1'b0; tb_a = '0; tb_b = '0; tb_cin = 1'b0;
    w4_start_valid = 1'b0; w4_done_ready = 1'b0; w4_a = '0; w4_b = '0; w4_cin = 1'b0;

    // Reset is asynchronous: outputs must be at reset values before any edge
    #2;
    chk("reset_state", {12'd0, start_ready, busy, done_valid, cout, sum},
        {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    chk("reset_state_w4", {26'd0, w4_start_ready, w4_busy, w4_done_valid, w4_cout, w4_sum},
        {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].s, vecs[i].co, 0, i % 3);
    end

    // Nibble-by-nibble fill, LSB first; prior result must be cleared on accept
    tb_a = 16'h1234; tb_b = 16'h4321; tb_cin = 1'b1; start_valid = 1'b1;
    tick();
    start_valid = 1'b0; tb_a = 16'hFFFF; tb_b = 16'hFFFF; tb_cin = 1'b0;
    chk("fill_clear", {15'd0, busy, sum}, {15'd0, 1'b1, 16'h0000});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("fill_step%0d", i), 32'(sum), 32'(fill[i]));
    end
    chk("fill_done", {30'd0, done_valid, cout}, {30'd0, 1'b1, 1'b0});
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;

    // Backpressure with start_valid held high throughout RUN and DONE
    tb_a = 16'h0F0F; tb_b = 16'h00F1; tb_cin = 1'b0; start_valid = 1'b1;
    tick();
    n = 0;
    while (!done_valid && n < 16) begin
      tb_a = 16'($urandom); tb_b = 16'($urandom);
      tick();
      n++;
    end
    chk("bp_latency", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      tb_a = 16'($urandom); tb_b = 16'($urandom); tb_cin = 1'($urandom);
      tick();
      chk("bp_hold", {13'd0, start_ready, done_valid, cout, sum},
          {13'd0, 1'b0, 1'b1, 1'b0, 16'h1000});
    end
    tb_a = 16'h0002; tb_b = 16'h0003; tb_cin = 1'b0; done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("bp_release", {12'd0, start_ready, busy, done_valid, cout, sum},
        {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000});
    tick();
    start_valid = 1'b0;
    chk("bp_accept", 32'(busy), 32'd1);
    n = 0;
    while (!done_valid && n < 16) begin
      tick();
      n++;
    end
    chk("bp_next_result", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h0005});
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;

    // Asynchronous reset in the middle of RUN at idx=2
    tb_a = 16'h1111; tb_b = 16'h1111; tb_cin = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    chk("abort_partial", 32'(sum), 32'h0022);
    #2 rst = 1'b1;
    #1;
    chk("abort_reset", {12'd0, start_ready, busy, done_valid, cout, sum},
        {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_valid || busy) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    do_op("post_reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0, 0);

    // 4-bit instance: single nibble step
    do_op4("w4_max", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
    do_op4("w4_nocarry", 4'h8, 4'h7, 1'b0, 4'hF, 1'b0);
    do_op4("w4_wrap", 4'h1, 4'hF, 1'b0, 4'h0, 1'b1);

    // Random regression with valid/ready gaps against an integer reference
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      ref_v = 17'(ra) + 17'(rb) + 17'(rc);
      do_op("rand", ra, rb, rc, ref_v[15:0], ref_v[16],
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ripple_add_sequencer.md
RIPPLE_ADD_SEQUENCER -- requirements
Module: ripple_add_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, operand width in bits; must be a multiple of 4 and at least 4.
REQ-002 SHALL have derived constant: NIB = WIDTH/4, the number of nibble steps per operation.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port: start_valid  input  1  request to start an addition.
REQ-006 SHALL have port: start_ready  output  1  block can accept a request.
REQ-007 SHALL have ports: a, b  input  WIDTH  operands, sampled only on an accepted request.
REQ-008 SHALL have port: cin  input  1  carry-in, sampled only on an accepted request.
REQ-009 SHALL have port: sum  output  WIDTH  result register.
REQ-010 SHALL have port: cout  output  1  final carry-out.
REQ-011 SHALL have port: done_valid  output  1  sum and cout are valid.
REQ-012 SHALL have port: done_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port: busy  output  1  high in RUN.

Function
REQ-014 SHALL compute {cout,sum} = a + b + cin using exactly one 4-bit ripple-carry adder slice, reused once per nibble, LSB nibble first.
REQ-015 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-016 IDLE: start_ready=1, busy=0, done_valid=0.
REQ-017 IDLE, on start_valid=1 at an edge (accept): SHALL capture a, b, cin into internal registers, clear sum to 0, set the nibble index to 0, and go to RUN.
REQ-018 RUN: start_ready=0, busy=1; each edge SHALL add nibble[idx] of the captured a and b plus the carry register, write the slice sum into sum[4*idx+3:4*idx], load the slice carry-out into the carry register, and increment idx.
REQ-019 RUN with idx=NIB-1: on that edge SHALL also load cout from the slice carry-out and go to DONE.
REQ-020 Latency: accept at edge k; done_valid SHALL be 1 after edge k+NIB.
REQ-021 DONE: done_valid=1, start_ready=0; sum and cout SHALL be held stable until handshake.
REQ-022 DONE, on done_ready=1 at an edge: SHALL go to IDLE; sum and cout SHALL retain their values until the next accept.
REQ-023 DONE to IDLE SHALL NOT accept a new request in the same edge; back-to-back throughput is one operation per NIB+2 cycles.
REQ-024 start_valid in RUN or DONE SHALL be ignored, with no capture and no state effect.
REQ-025 Changes on a, b, or cin after accept SHALL NOT affect the result.
REQ-026 done_ready in IDLE or RUN SHALL be ignored.
REQ-027 Carries SHALL propagate across nibble boundaries only through the carry register; no combinational path from inputs to sum or cout.
REQ-028 Overflow SHALL wrap modulo 2^WIDTH in sum, with the carry reported in cout only.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force: state=IDLE, sum=0, cout=0, carry register=0, idx=0, done_valid=0, busy=0, start_ready=1.
REQ-030 rst asserted mid-RUN or in DONE SHALL abort the operation and discard the partial result; no done_valid SHALL follow.
REQ-031 After rst deasserts, the first accept SHALL be possible on the next rising edge.

Verification
REQ-032 WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, done_valid 4 edges after accept.
REQ-033 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; during RUN, sum nibbles fill LSB first (0x0006, 0x0056, 0x0556, 0x5556).
REQ-034 Backpressure: hold done_ready=0 for 10 cycles with a and b changing and start_valid=1 -> sum, cout, done_valid stable, no new accept; release -> IDLE, then accept on the following edge.
REQ-035 Assert rst asynchronously between edges at idx=2 -> outputs reach reset values before the next edge; new op 0x00FF+0x0001 -> sum=0x0100, cout=0.
REQ-036 WIDTH=4: a=0xF, b=0xF, cin=1 -> sum=0xF, cout=1, done_valid 1 edge after accept.
REQ-037 Random regression: 1000 ops with random valid/ready gaps -> every result equals a+b+cin against the reference model.
